// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the control-word layout and the load-use test.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT,
        FLUSH
    } state_t;

    // One control word drives the PC enable, four buffer enables and two flushes.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0
    };

    localparam ctrl_t CTRL_FREEZE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0
    };

    localparam ctrl_t CTRL_FLUSH = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1
    };

    // Hold IF and ID, inject a bubble into EX, let the back end drain.
    localparam ctrl_t CTRL_BUBBLE = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1
    };

    localparam ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b1, idex_flush: 1'b1
    };

    // A load into $zero never creates a real dependency.
    function automatic logic load_use(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for a five-stage pipeline: resolves memory freezes,
// taken branches and load-use hazards into buffer enables and bubble flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int unsigned TMO    = (MEM_TIMEOUT < 1) ? 1 : MEM_TIMEOUT;
    localparam int unsigned WAIT_W = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TMO - 1);

    state_t            state;
    state_t            next_state;
    ctrl_t             ctrl;
    logic              lu;
    logic              lu_live;
    logic [WAIT_W-1:0] wait_cnt;

    assign lu = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    // The bubble just inserted already separates the pair, so a repeat lu is ignored.
    assign lu_live = lu && (state != LU_STALL) && (state != FLUSH);

    always_comb begin
        ctrl       = CTRL_RUN;
        next_state = RUN;
        if (!rst_n) begin
            ctrl       = CTRL_RESET;
            next_state = RUN;
        end else if (mem_busy) begin
            ctrl       = CTRL_FREEZE;
            next_state = MEM_WAIT;
        end else if (branch_taken) begin
            ctrl       = CTRL_FLUSH;
            next_state = FLUSH;
        end else if (lu_live) begin
            ctrl       = CTRL_BUBBLE;
            next_state = LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (!ctrl.pc_en),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (ctrl.ifid_flush),
        .count (flush_cnt)
    );

    // Counts consecutive busy cycles; any ready cycle restarts it.
    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!mem_busy),
        .inc   (mem_busy),
        .count (wait_cnt)
    );

    // Set on the edge where the wait count reaches the limit; sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (mem_busy && (wait_cnt >= TMO_LAST)) begin
            mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_ctrl;

    localparam int unsigned MEM_TIMEOUT = 3;
    localparam int unsigned CNT_W       = 4;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;
    localparam logic [1:0] FL_NONE = 2'b00;
    localparam logic [1:0] FL_BOTH = 2'b11;
    localparam logic [1:0] FL_LU   = 2'b01;

    typedef struct {
        string      name;
        logic [4:0] en;
        logic [1:0] fl;
        int         sc;
        int         fc;
        logic       to;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, branch_taken, mem_busy;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rt        (ex_rt),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s.%s: got %0d expected %0d at %0t", nm, field, act, exp, $time);
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "enables", int'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), int'(e.en));
            chk(e.name, "flushes", int'({ifid_flush, idex_flush}), int'(e.fl));
            chk(e.name, "stall_cnt", int'(stall_cnt), e.sc);
            chk(e.name, "flush_cnt", int'(flush_cnt), e.fc);
            chk(e.name, "mem_timeout", int'(mem_timeout), int'(e.to));
        end
    end

    task automatic step(
        input string nm, input logic rst,
        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
        input logic [4:0] exrt, input logic mrd, input logic br, input logic mb,
        input logic [4:0] en, input logic [1:0] fl, input int sc, input int fc, input logic to
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_rt = exrt; ex_mem_read = mrd; branch_taken = br; mem_busy = mb;
        e.name = nm; e.en = en; e.fl = fl; e.sc = sc; e.fc = fc; e.to = to;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b1;
        ex_rt = 5'd3; ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;

        //    name             rst rs rt urt exrt mrd br mb  enables  flushes  sc fc to
        step("reset",          0, 1, 2, 1, 3, 0, 0, 0, EN_NONE, FL_BOTH, 0, 0, 0);
        step("post_reset",     1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0, 0);
        step("lu_rs",          1, 5, 2, 1, 5, 1, 0, 0, EN_LU,   FL_LU,   0, 0, 0);
        step("lu_ignored",     1, 5, 2, 1, 5, 1, 0, 0, EN_ALL,  FL_NONE, 1, 0, 0);
        step("after_lu",       1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 1, 0, 0);
        step("zero_load",      1, 0, 0, 1, 0, 1, 0, 0, EN_ALL,  FL_NONE, 1, 0, 0);
        step("lu_rt",          1, 3, 7, 1, 7, 1, 0, 0, EN_LU,   FL_LU,   1, 0, 0);
        step("idle_a",         1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 2, 0, 0);
        step("rt_not_used",    1, 3, 7, 0, 7, 1, 0, 0, EN_ALL,  FL_NONE, 2, 0, 0);
        step("branch",         1, 1, 2, 1, 3, 0, 1, 0, EN_ALL,  FL_BOTH, 2, 0, 0);
        step("lu_in_flush",    1, 5, 2, 1, 5, 1, 0, 0, EN_ALL,  FL_NONE, 2, 1, 0);
        step("lu_again",       1, 5, 2, 1, 5, 1, 0, 0, EN_LU,   FL_LU,   2, 1, 0);
        step("br_in_lu_stall", 1, 5, 2, 1, 5, 1, 1, 0, EN_ALL,  FL_BOTH, 3, 1, 0);
        step("idle_b",         1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 3, 2, 0);
        step("branch_and_lu",  1, 5, 2, 1, 5, 1, 1, 0, EN_ALL,  FL_BOTH, 3, 2, 0);
        step("idle_c",         1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 3, 3, 0);
        for (int k = 0; k < 4; k++)
            step("mem_wait",   1, 1, 2, 1, 3, 0, 0, 1, EN_NONE, FL_NONE, 3 + k, 3, (k == 3));
        step("mem_done",       1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 7, 3, 1);
        for (int k = 0; k < 2; k++)
            step("branch_frozen", 1, 1, 2, 1, 3, 0, 1, 1, EN_NONE, FL_NONE, 7 + k, 3, 1);
        step("branch_released", 1, 1, 2, 1, 3, 0, 1, 0, EN_ALL, FL_BOTH, 9, 3, 1);
        step("idle_d",         1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 9, 4, 1);
        for (int k = 0; k < 8; k++)
            step("stall_saturate", 1, 1, 2, 1, 3, 0, 0, 1, EN_NONE, FL_NONE,
                 (9 + k > 15) ? 15 : 9 + k, 4, 1);
        step("reset_mem_wait", 0, 1, 2, 1, 3, 0, 0, 1, EN_NONE, FL_BOTH, 15, 4, 1);
        step("reset_release",  1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 0, 0, 0);
        step("branch_2",       1, 1, 2, 1, 3, 0, 1, 0, EN_ALL,  FL_BOTH, 0, 0, 0);
        step("reset_in_flush", 0, 1, 2, 1, 3, 0, 0, 0, EN_NONE, FL_BOTH, 0, 1, 0);
        step("lu_after_reset", 1, 5, 2, 1, 5, 1, 0, 0, EN_LU,   FL_LU,   0, 0, 0);
        step("idle_e",         1, 1, 2, 1, 3, 0, 0, 0, EN_ALL,  FL_NONE, 1, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum consecutive mem_busy cycles before mem_timeout sets.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 Port: id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-007 Port: ex_rt  in  5  destination register of the instruction in EX.
REQ-008 Port: ex_mem_read  in  1  EX instruction is a load.
REQ-009 Port: branch_taken  in  1  EX resolved a taken branch or jump.
REQ-010 Port: mem_busy  in  1  data memory not ready; MEM must hold.
REQ-011 Port: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables for the PC and the four pipeline buffers.
REQ-012 Port: ifid_flush, idex_flush  out  1 each  load a bubble (all-zero) into that buffer this edge.
REQ-013 Port: stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.
REQ-014 Port: mem_timeout  out  1  sticky error flag.

Function
REQ-015 FSM states are RUN, LU_STALL, MEM_WAIT and FLUSH; control outputs decode combinationally from state and current inputs.
REQ-016 Load-use hazard is defined as lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
REQ-017 Priority, highest first: mem_busy, branch_taken, lu, none.
REQ-018 mem_busy=1 in any state: all five enables 0, both flushes 0, next state MEM_WAIT.
REQ-019 branch_taken=1 with mem_busy=0: all enables 1, ifid_flush=1, idex_flush=1, next state FLUSH.
REQ-020 lu=1 with no higher-priority event: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1, memwb_en=1, next state LU_STALL.
REQ-021 No event: all enables 1, flushes 0, next state RUN.
REQ-022 In LU_STALL and FLUSH, lu is ignored for one cycle, which prevents a duplicate bubble; mem_busy and branch_taken are still honoured.
REQ-023 MEM_WAIT: a wait counter increments each cycle mem_busy=1 and clears when mem_busy falls; the cycle mem_busy=0 decodes as RUN.
REQ-024 mem_timeout sets when the wait counter reaches MEM_TIMEOUT, and stays set until reset.
REQ-025 stall_cnt increments on each cycle where pc_en=0; it saturates at all-ones and does not wrap.
REQ-026 flush_cnt increments on each cycle where ifid_flush=1; it saturates at all-ones.
REQ-027 branch_taken together with mem_busy: the freeze wins, with no flush and no flush_cnt increment; the branch is taken on the first cycle mem_busy=0, because EX holds its contents while frozen.
REQ-028 branch_taken together with lu: the flush wins, and no LU bubble is counted.

Reset
REQ-029 While rst_n=0 at a clock edge, the next state is RUN and the wait counter, stall_cnt, flush_cnt and mem_timeout are cleared to 0.
REQ-030 While rst_n=0, all enables are 0 and both flushes are 1, so the buffers fill with bubbles.
REQ-031 Reset asserted mid-operation (MEM_WAIT or FLUSH) abandons that operation, with no residual stall after release.
REQ-032 On the first cycle after release, with no events, all enables are 1.

Structure
REQ-033 Shared package pipe_ctrl_pkg holds the following:
- the state enumeration;
- the register-number width (5);
- the default CNT_W.
REQ-034 One sub-module, sat_counter (parameter width W; increment, synchronous clear, saturate), is instantiated for stall_cnt, flush_cnt and the wait counter.
REQ-035 The block has no datapath registers; it drives only the existing pipeline buffer enables and flushes.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; next cycle all enables 1; stall_cnt=1.
REQ-037 $zero load: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall; stall_cnt stays 0.
REQ-038 Branch: branch_taken=1 for 1 cycle -> ifid_flush=1, idex_flush=1, all enables 1; flush_cnt=1; state FLUSH then RUN.
REQ-039 Memory wait: mem_busy=1 for 4 cycles with MEM_TIMEOUT=3 -> all enables 0 for 4 cycles, mem_timeout=1 from cycle 4 and held, stall_cnt=4.
REQ-040 Simultaneous events and reset:
- branch_taken=1 plus mem_busy=1 for 2 cycles, then mem_busy=0 -> flushes only on cycle 3; flush_cnt=1.
- rst_n=0 during MEM_WAIT -> counters 0, state RUN.
